// File: rtl/mem_router_pkg.sv
// rtl/mem_router_pkg.sv - shared types, error codes and helpers for the memory region router
package mem_router_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_code_e;

    localparam logic [31:0] UNMAPPED_DATA_DEFAULT = 32'hDEADBEEF;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_router_timer.sv
// rtl/mem_router_timer.sv - saturating access timeout counter
module mem_router_timer
    import mem_router_pkg::*;
#(
    parameter int LIMIT = 255,
    parameter int W     = clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_start,
    output logic o_expired
);

    logic [W-1:0] r_count;

    // Saturates at LIMIT so a stalled FSM can never see the count wrap back to 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_start && (r_count != W'(LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_region_router.sv
// rtl/mem_region_router.sv - routes one CPU memory request to an address-selected target port
module mem_region_router
    import mem_router_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int NUM_REGIONS    = 4,
    parameter int REGION_SHIFT   = 28,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] UNMAPPED_DATA = DATA_W'(UNMAPPED_DATA_DEFAULT)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mem_valid,
    input  logic                          mem_instr,
    input  logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W/8-1:0]           mem_wstrb,
    output logic                          mem_ready,
    output logic [DATA_W-1:0]             mem_rdata,
    output logic [NUM_REGIONS-1:0]        tgt_valid,
    output logic                          tgt_instr,
    output logic [ADDR_W-1:0]             tgt_addr,
    output logic [DATA_W-1:0]             tgt_wdata,
    output logic [DATA_W/8-1:0]           tgt_wstrb,
    input  logic [NUM_REGIONS-1:0]        tgt_ready,
    input  logic [NUM_REGIONS*DATA_W-1:0] tgt_rdata,
    output logic                          err_valid,
    output logic [1:0]                    err_code,
    output logic [ADDR_W-1:0]             err_addr,
    input  logic                          err_clear
);

    localparam int FIELD_W = ADDR_W - REGION_SHIFT;
    localparam int IDX_W   = (clog2(NUM_REGIONS) > 0) ? clog2(NUM_REGIONS) : 1;
    localparam int STRB_W  = DATA_W / 8;

    state_e                   r_state;
    logic [IDX_W-1:0]         r_idx;
    logic [NUM_REGIONS-1:0]   r_tgt_valid;
    logic                     r_tgt_instr;
    logic [ADDR_W-1:0]        r_tgt_addr;
    logic [DATA_W-1:0]        r_tgt_wdata;
    logic [STRB_W-1:0]        r_tgt_wstrb;
    logic                     r_mem_ready;
    logic [DATA_W-1:0]        r_mem_rdata;
    logic                     r_err_valid;
    logic [1:0]               r_err_code;
    logic [ADDR_W-1:0]        r_err_addr;

    logic [FIELD_W-1:0]       w_field;
    logic [NUM_REGIONS-1:0]   w_onehot;
    logic                     w_mapped;
    logic                     w_sel_ready;
    logic [DATA_W-1:0]        w_sel_rdata;
    logic                     w_expired;
    logic                     w_tmr_run;
    logic                     w_tmr_clear;
    logic                     w_err_unmapped;
    logic                     w_err_timeout;
    logic                     w_err_evt;
    logic [1:0]               w_err_code_new;
    logic [ADDR_W-1:0]        w_err_addr_new;

    assign w_field = mem_addr[ADDR_W-1:REGION_SHIFT];

    // A region field beyond NUM_REGIONS matches no one-hot bit, so "mapped" falls out of the decode.
    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            w_onehot[k] = (w_field == FIELD_W'(k));
        end
    end

    assign w_mapped = |w_onehot;

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sel_ready = tgt_ready[k];
                w_sel_rdata = tgt_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_tmr_run   = (r_state == ACCESS);
    assign w_tmr_clear = (r_state != ACCESS);

    mem_router_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_tmr_clear),
        .i_start   (w_tmr_run),
        .o_expired (w_expired)
    );

    assign w_err_unmapped = (r_state == IDLE) && mem_valid && !w_mapped;
    assign w_err_timeout  = (r_state == ACCESS) && !w_sel_ready && w_expired;
    assign w_err_evt      = w_err_unmapped || w_err_timeout;
    assign w_err_code_new = w_err_unmapped ? ERR_UNMAPPED : ERR_TIMEOUT;
    assign w_err_addr_new = w_err_unmapped ? mem_addr : r_tgt_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_tgt_valid <= '0;
            r_tgt_instr <= 1'b0;
            r_tgt_addr  <= '0;
            r_tgt_wdata <= '0;
            r_tgt_wstrb <= '0;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
        end else begin
            r_mem_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_valid) begin
                        r_tgt_instr <= mem_instr;
                        r_tgt_addr  <= mem_addr;
                        r_tgt_wdata <= mem_wdata;
                        r_tgt_wstrb <= mem_wstrb;
                        if (w_mapped) begin
                            r_idx       <= w_field[IDX_W-1:0];
                            r_tgt_valid <= w_onehot;
                            r_state     <= ACCESS;
                        end else begin
                            r_mem_ready <= 1'b1;
                            r_mem_rdata <= UNMAPPED_DATA;
                            r_state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (w_sel_ready) begin
                        r_tgt_valid <= '0;
                        r_mem_rdata <= (r_tgt_wstrb == '0) ? w_sel_rdata : '0;
                        r_mem_ready <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_expired) begin
                        r_tgt_valid <= '0;
                        r_mem_rdata <= UNMAPPED_DATA;
                        r_mem_ready <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_tgt_valid <= '0;
                end
            endcase
        end
    end

    // First error sticks; a clear in the same cycle as a new error lets the new one in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_addr  <= '0;
        end else if (w_err_evt && (!r_err_valid || err_clear)) begin
            r_err_valid <= 1'b1;
            r_err_code  <= w_err_code_new;
            r_err_addr  <= w_err_addr_new;
        end else if (err_clear) begin
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_addr  <= '0;
        end
    end

    assign mem_ready = r_mem_ready;
    assign mem_rdata = r_mem_rdata;
    assign tgt_valid = r_tgt_valid;
    assign tgt_instr = r_tgt_instr;
    assign tgt_addr  = r_tgt_addr;
    assign tgt_wdata = r_tgt_wdata;
    assign tgt_wstrb = r_tgt_wstrb;
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_mem_region_router.sv
// tb/tb_mem_region_router.sv - directed self-checking bench for mem_region_router
module tb_mem_region_router;

    logic         clock;
    logic         reset;
    logic         mem_valid;
    logic         mem_instr;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [3:0]   tgt_valid;
    logic         tgt_instr;
    logic [31:0]  tgt_addr;
    logic [31:0]  tgt_wdata;
    logic [3:0]   tgt_wstrb;
    logic [3:0]   tgt_ready;
    logic [127:0] tgt_rdata;
    logic         err_valid;
    logic [1:0]   err_code;
    logic [31:0]  err_addr;
    logic         err_clear;

    int n_checks = 0;
    int n_fail   = 0;

    mem_region_router #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .tgt_valid (tgt_valid),
        .tgt_instr (tgt_instr),
        .tgt_addr  (tgt_addr),
        .tgt_wdata (tgt_wdata),
        .tgt_wstrb (tgt_wstrb),
        .tgt_ready (tgt_ready),
        .tgt_rdata (tgt_rdata),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_addr  (err_addr),
        .err_clear (err_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Presents a request, lets it be accepted on the next edge, then drops valid.
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        mem_valid = 1'b1;
        mem_instr = 1'b0;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        tick();
        mem_valid = 1'b0;
    endtask

    // Runs an ACCESS that never completes; returns cycles tgt_valid[0] was high and cycles waited.
    task automatic run_timeout(input logic [31:0] addr, output int hi, output int waited);
        tgt_ready = 4'b1110;
        issue(addr, 32'h0, 4'h0);
        hi = 0;
        waited = 0;
        while (!mem_ready && waited < 40) begin
            if (tgt_valid === 4'b0001) hi++;
            tick();
            waited++;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        tgt_ready = '0;
        tgt_rdata = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'h00000000};
        err_clear = 1'b0;
        #3;
        n_checks++; if ({mem_ready, tgt_valid, err_valid} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {mem_ready, tgt_valid, err_valid}); end
        n_checks++; if ({mem_rdata, tgt_addr, tgt_wdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {mem_rdata, tgt_addr, tgt_wdata}); end
        n_checks++; if ({err_code, err_addr, tgt_wstrb, tgt_instr} !== 39'h0) begin n_fail++; $display("FAIL reset_err: got %h expected 0", {err_code, err_addr, tgt_wstrb, tgt_instr}); end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write;
        tgt_ready = 4'b0100;
        issue(32'h20000000, 32'h1234abcd, 4'b1111);
        n_checks++; if (tgt_valid !== 4'b0100) begin n_fail++; $display("FAIL wr_tgt_valid: got %b expected 0100", tgt_valid); end
        n_checks++; if (tgt_wdata !== 32'h1234abcd) begin n_fail++; $display("FAIL wr_tgt_wdata: got %h expected 1234abcd", tgt_wdata); end
        n_checks++; if ({tgt_addr, tgt_wstrb} !== {32'h20000000, 4'hf}) begin n_fail++; $display("FAIL wr_tgt_addr_strb: got %h expected 20000000f", {tgt_addr, tgt_wstrb}); end
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL wr_early_ready: got %b expected 0", mem_ready); end
        tick();
        n_checks++; if ({mem_ready, tgt_valid} !== 5'b10000) begin n_fail++; $display("FAIL wr_resp: got %b expected 10000", {mem_ready, tgt_valid}); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h expected 0", mem_rdata); end
        tick();
        n_checks++; if ({mem_ready, err_valid} !== 2'b00) begin n_fail++; $display("FAIL wr_after: got %b expected 00", {mem_ready, err_valid}); end
        tgt_ready = 4'b0000;
    endtask

    task automatic test_read_wait;
        int hi;
        hi = 0;
        tgt_ready = 4'b1101;
        issue(32'h10000004, 32'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            if (tgt_valid === 4'b0010) hi++;
            if (c == 3) tgt_ready = 4'b0010;
            tick();
        end
        n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL rd_valid_cycles: got %0d expected 4", hi); end
        n_checks++; if ({mem_ready, tgt_valid} !== 5'b10000) begin n_fail++; $display("FAIL rd_resp: got %b expected 10000", {mem_ready, tgt_valid}); end
        n_checks++; if (mem_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_rdata: got %h expected cafef00d", mem_rdata); end
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL rd_no_err: got %b expected 0", err_valid); end
        tgt_ready = 4'b0000;
        tick();
    endtask

    task automatic test_unmapped;
        tgt_ready = 4'b1111;
        issue(32'h50000000, 32'h0, 4'h0);
        n_checks++; if ({mem_ready, tgt_valid} !== 5'b10000) begin n_fail++; $display("FAIL um_resp: got %b expected 10000", {mem_ready, tgt_valid}); end
        n_checks++; if (mem_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL um_rdata: got %h expected deadbeef", mem_rdata); end
        n_checks++; if ({err_valid, err_code} !== 3'b101) begin n_fail++; $display("FAIL um_err: got %b expected 101", {err_valid, err_code}); end
        n_checks++; if (err_addr !== 32'h50000000) begin n_fail++; $display("FAIL um_err_addr: got %h expected 50000000", err_addr); end
        tick();
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL um_ready_pulse: got %b expected 0", mem_ready); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_checks++; if ({err_valid, err_code, err_addr} !== 35'h0) begin n_fail++; $display("FAIL um_clear: got %h expected 0", {err_valid, err_code, err_addr}); end
        tgt_ready = 4'b0000;
    endtask

    task automatic test_timeout;
        int hi;
        int waited;
        run_timeout(32'h00000000, hi, waited);
        n_checks++; if (waited >= 40) begin n_fail++; $display("FAIL to_bound: got %0d cycles expected response before 40", waited); end
        n_checks++; if (hi !== 8) begin n_fail++; $display("FAIL to_valid_cycles: got %0d expected 8", hi); end
        n_checks++; if (mem_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_rdata: got %h expected deadbeef", mem_rdata); end
        n_checks++; if ({err_valid, err_code, tgt_valid} !== 7'b1100000) begin n_fail++; $display("FAIL to_err: got %b expected 1100000", {err_valid, err_code, tgt_valid}); end
        tick();
        run_timeout(32'h00000040, hi, waited);
        n_checks++; if ({waited < 40, hi} !== {1'b1, 32'd8}) begin n_fail++; $display("FAIL to2_cycles: got waited=%0d hi=%0d expected <40 and 8", waited, hi); end
        n_checks++; if ({err_valid, err_code, err_addr} !== {3'b110, 32'h0}) begin n_fail++; $display("FAIL to2_sticky: got %h expected %h", {err_valid, err_code, err_addr}, {3'b110, 32'h0}); end
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_checks++; if ({err_valid, err_code} !== 3'b000) begin n_fail++; $display("FAIL to_clear: got %b expected 000", {err_valid, err_code}); end
        tgt_ready = 4'b0000;
    endtask

    task automatic test_clear_collision;
        int hi;
        int waited;
        run_timeout(32'h00000080, hi, waited);
        tick();
        n_checks++; if ({err_valid, err_code, err_addr} !== {3'b110, 32'h80}) begin n_fail++; $display("FAIL cc_first: got %h expected %h", {err_valid, err_code, err_addr}, {3'b110, 32'h80}); end
        err_clear = 1'b1;
        issue(32'hF0000000, 32'h0, 4'h0);
        err_clear = 1'b0;
        n_checks++; if ({err_valid, err_code, err_addr} !== {3'b101, 32'hF0000000}) begin n_fail++; $display("FAIL cc_new: got %h expected %h", {err_valid, err_code, err_addr}, {3'b101, 32'hF0000000}); end
        tick();
        tgt_ready = 4'b0000;
    endtask

    task automatic test_reset_mid;
        int pulses;
        issue(32'h30000000, 32'h0, 4'h0);
        n_checks++; if (tgt_valid !== 4'b1000) begin n_fail++; $display("FAIL rm_access: got %b expected 1000", tgt_valid); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if ({tgt_valid, mem_ready} !== 5'b0) begin n_fail++; $display("FAIL rm_async: got %b expected 00000", {tgt_valid, mem_ready}); end
        n_checks++; if ({mem_rdata, tgt_addr, err_valid} !== 65'h0) begin n_fail++; $display("FAIL rm_regs: got %h expected 0", {mem_rdata, tgt_addr, err_valid}); end
        tick();
        reset = 1'b1;
        tgt_ready = 4'b1000;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (mem_ready === 1'b1 || tgt_valid !== 4'b0000) pulses++;
            tick();
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rm_no_resp: got %0d activity cycles expected 0", pulses); end
        issue(32'h30000008, 32'h000055aa, 4'b0011);
        tick();
        n_checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rm_next: got %h expected %h", {mem_ready, mem_rdata}, {1'b1, 32'h0}); end
        tick();
        tgt_ready = 4'b0000;
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        tgt_ready = 4'b0100;
        mem_valid = 1'b1;
        mem_addr  = 32'h20000010;
        mem_wdata = 32'h0badf00d;
        mem_wstrb = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_ready === 1'b1) pulses++;
        end
        mem_valid = 1'b0;
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        tgt_ready = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_unmapped();
        test_timeout();
        test_clear_collision();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
